// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed digit scanner.
// Feeds a 7-segment decoder via scan_bcd and drives active-low digit enables.
module bcd_scan_counter #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  up_dn,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic [3:0]            scan_bcd,
    output logic [DIGITS-1:0]     scan_sel
);

    localparam int unsigned CNT_W = 4 * DIGITS;
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]  r_count;
    logic              r_carry;
    logic [DIV_W-1:0]  r_div;
    logic [IDX_W-1:0]  r_idx;
    logic [3:0]        r_scan_bcd;
    logic [DIGITS-1:0] r_scan_sel;

    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_carry_nxt;
    logic              w_chain;
    logic              w_div_tc;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [3:0]        w_scan_bcd_nxt;
    logic [DIGITS-1:0] w_scan_sel_nxt;

    // Next count: clear beats load beats count step; ripple spans all digits.
    always_comb begin
        w_count_nxt = r_count;
        w_carry_nxt = 1'b0;
        w_chain     = 1'b0;
        if (clr) begin
            w_count_nxt = '0;
        end else if (load) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (load_val[4*i +: 4] > 4'd9) begin
                    w_count_nxt[4*i +: 4] = 4'd0;
                end else begin
                    w_count_nxt[4*i +: 4] = load_val[4*i +: 4];
                end
            end
        end else if (en) begin
            w_chain = 1'b1;
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (w_chain) begin
                    if (up_dn) begin
                        if (r_count[4*i +: 4] == 4'd9) begin
                            w_count_nxt[4*i +: 4] = 4'd0;
                        end else begin
                            w_count_nxt[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                            w_chain = 1'b0;
                        end
                    end else begin
                        if (r_count[4*i +: 4] == 4'd0) begin
                            w_count_nxt[4*i +: 4] = 4'd9;
                        end else begin
                            w_count_nxt[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                            w_chain = 1'b0;
                        end
                    end
                end
            end
            w_carry_nxt = w_chain;
        end
    end

    assign w_div_tc = (r_div == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_div_tc) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Scan FSM state register: the state is the selected digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else begin
            r_idx <= w_idx_nxt;
        end
    end

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_div_tc) begin
            if (r_idx == IDX_W'(DIGITS - 1)) begin
                w_idx_nxt = '0;
            end else begin
                w_idx_nxt = r_idx + IDX_W'(1);
            end
        end
    end

    // Scan outputs come from next-state index and next-state count together.
    always_comb begin
        w_scan_bcd_nxt = 4'd0;
        w_scan_sel_nxt = '1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_scan_bcd_nxt = w_count_nxt[4*i +: 4];
                w_scan_sel_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_carry    <= 1'b0;
            r_scan_bcd <= 4'd0;
            r_scan_sel <= ~DIGITS'(1);
        end else begin
            r_count    <= w_count_nxt;
            r_carry    <= w_carry_nxt;
            r_scan_bcd <= w_scan_bcd_nxt;
            r_scan_sel <= w_scan_sel_nxt;
        end
    end

    assign count    = r_count;
    assign carry    = r_carry;
    assign scan_bcd = r_scan_bcd;
    assign scan_sel = r_scan_sel;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with DIGITS=4, SCAN_DIV=4.
module tb_bcd_scan_counter;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic        en;
    logic        up_dn;
    logic [15:0] count;
    logic        carry;
    logic [3:0]  scan_bcd;
    logic [3:0]  scan_sel;

    int n_vec;
    int n_err;

    bcd_scan_counter #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up_dn    (up_dn),
        .count    (count),
        .carry    (carry),
        .scan_bcd (scan_bcd),
        .scan_sel (scan_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Async reset pulse away from any clock edge; leaves time at posedge+4.
    task automatic pulse_reset();
        tick();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        load = 1'b1; load_val = 16'h0123;
        tick();
        load = 1'b0;
        n_vec++;
        if (count !== 16'h0123) begin
            n_err++; $display("FAIL reset_preload: count got %h want 0123", count);
        end
        repeat (5) tick();
        n_vec++;
        if (scan_sel !== 4'b1101 || scan_bcd !== 4'd2) begin
            n_err++; $display("FAIL reset_prescan: sel/bcd got %b/%0d want 1101/2", scan_sel, scan_bcd);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (count !== 16'h0000 || carry !== 1'b0) begin
            n_err++; $display("FAIL reset_async_count: count/carry got %h/%b want 0000/0", count, carry);
        end
        n_vec++;
        if (scan_sel !== 4'b1110 || scan_bcd !== 4'd0) begin
            n_err++; $display("FAIL reset_async_scan: sel/bcd got %b/%0d want 1110/0", scan_sel, scan_bcd);
        end
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_up_wrap();
        load = 1'b1; load_val = 16'h9998;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        n_vec++;
        if (count !== 16'h9998) begin
            n_err++; $display("FAIL up_load: count got %h want 9998", count);
        end
        tick();
        n_vec++;
        if (count !== 16'h9999 || carry !== 1'b0) begin
            n_err++; $display("FAIL up_step1: count/carry got %h/%b want 9999/0", count, carry);
        end
        tick();
        en = 1'b0;
        n_vec++;
        if (count !== 16'h0000 || carry !== 1'b1) begin
            n_err++; $display("FAIL up_wrap: count/carry got %h/%b want 0000/1", count, carry);
        end
        tick();
        n_vec++;
        if (count !== 16'h0000 || carry !== 1'b0) begin
            n_err++; $display("FAIL up_hold: count/carry got %h/%b want 0000/0", count, carry);
        end
    endtask

    task automatic test_down_borrow();
        load = 1'b1; load_val = 16'h1000;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        tick();
        en = 1'b0;
        n_vec++;
        if (count !== 16'h0999 || carry !== 1'b0) begin
            n_err++; $display("FAIL down_borrow: count/carry got %h/%b want 0999/0", count, carry);
        end
        load = 1'b1; load_val = 16'h0000;
        tick();
        load = 1'b0; en = 1'b1;
        n_vec++;
        if (count !== 16'h0000) begin
            n_err++; $display("FAIL down_load0: count got %h want 0000", count);
        end
        tick();
        en = 1'b0;
        n_vec++;
        if (count !== 16'h9999 || carry !== 1'b1) begin
            n_err++; $display("FAIL down_wrap: count/carry got %h/%b want 9999/1", count, carry);
        end
        tick();
        n_vec++;
        if (count !== 16'h9999 || carry !== 1'b0) begin
            n_err++; $display("FAIL down_hold: count/carry got %h/%b want 9999/0", count, carry);
        end
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_val = 16'hA5F3;
        tick();
        n_vec++;
        if (count !== 16'h0503) begin
            n_err++; $display("FAIL invalid_load: count got %h want 0503", count);
        end
        load_val = 16'h0042; en = 1'b1; up_dn = 1'b1;
        tick();
        n_vec++;
        if (count !== 16'h0042) begin
            n_err++; $display("FAIL load_over_en: count got %h want 0042", count);
        end
        clr = 1'b1; load_val = 16'h1234;
        tick();
        clr = 1'b0; load = 1'b0; en = 1'b0;
        n_vec++;
        if (count !== 16'h0000 || carry !== 1'b0) begin
            n_err++; $display("FAIL clr_priority: count/carry got %h/%b want 0000/0", count, carry);
        end
        load = 1'b1; load_val = 16'h9999;
        tick();
        load = 1'b0; clr = 1'b1; en = 1'b1; up_dn = 1'b1;
        tick();
        clr = 1'b0; en = 1'b0;
        n_vec++;
        if (count !== 16'h0000 || carry !== 1'b0) begin
            n_err++; $display("FAIL clr_no_carry: count/carry got %h/%b want 0000/0", count, carry);
        end
    endtask

    task automatic test_scan_sequence();
        logic [3:0] exp_sel [4];
        logic [3:0] exp_bcd [4];
        int k;
        exp_sel[0] = 4'b1110; exp_bcd[0] = 4'd1;
        exp_sel[1] = 4'b1101; exp_bcd[1] = 4'd2;
        exp_sel[2] = 4'b1011; exp_bcd[2] = 4'd3;
        exp_sel[3] = 4'b0111; exp_bcd[3] = 4'd4;
        pulse_reset();
        load = 1'b1; load_val = 16'h4321;
        for (int e = 1; e <= 20; e++) begin
            tick();
            load = 1'b0;
            k = (e / 4) % 4;
            n_vec++;
            if (scan_sel !== exp_sel[k] || scan_bcd !== exp_bcd[k]) begin
                n_err++;
                $display("FAIL scan_edge%0d: sel/bcd got %b/%0d want %b/%0d",
                         e, scan_sel, scan_bcd, exp_sel[k], exp_bcd[k]);
            end
        end
    endtask

    task automatic test_count_during_scan();
        pulse_reset();
        load = 1'b1; load_val = 16'h0008;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        n_vec++;
        if (scan_bcd !== 4'd8 || scan_sel !== 4'b1110) begin
            n_err++; $display("FAIL live_load: sel/bcd got %b/%0d want 1110/8", scan_sel, scan_bcd);
        end
        tick();
        n_vec++;
        if (count !== 16'h0009 || scan_bcd !== 4'd9) begin
            n_err++; $display("FAIL live_step: count/bcd got %h/%0d want 0009/9", count, scan_bcd);
        end
        tick();
        en = 1'b0;
        n_vec++;
        if (count !== 16'h0010 || scan_bcd !== 4'd0 || scan_sel !== 4'b1110) begin
            n_err++; $display("FAIL live_ripple: count/sel/bcd got %h/%b/%0d want 0010/1110/0",
                              count, scan_sel, scan_bcd);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b1;
        #11;
        n_vec++;
        if (count !== 16'h0000 || carry !== 1'b0 || scan_sel !== 4'b1110 || scan_bcd !== 4'd0) begin
            n_err++; $display("FAIL reset_values: count/carry/sel/bcd got %h/%b/%b/%0d want 0000/0/1110/0",
                              count, carry, scan_sel, scan_bcd);
        end
        #1;
        rst_n = 1'b1;
        test_reset();
        test_up_wrap();
        test_down_borrow();
        test_load_priority();
        test_scan_sequence();
        test_count_during_scan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Multi-digit BCD up/down counter with a time-multiplexed digit scanner. It sits directly upstream of the 4-bit-to-7-segment decoder: the decoder's 4-bit input comes from `scan_bcd`, and `scan_sel` drives the common digit enables of a multiplexed display. Every BCD value this block presents is in the range 0–9, so the decoder's default branch is never exercised.

## Interface
Parameters:
- `DIGITS`, default 4: number of BCD digits (2–8).
- `SCAN_DIV`, default 1000: clock cycles each digit stays selected (≥2).

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `clr`, input, 1: synchronous clear of the count.
- `load`, input, 1: synchronous load of `load_val`.
- `load_val`, input, 4*DIGITS: packed BCD load value; digit 0 is bits [3:0].
- `en`, input, 1: count-step enable; one step per high cycle.
- `up_dn`, input, 1: count direction; 1 = up, 0 = down.
- `count`, output, 4*DIGITS: registered packed BCD count.
- `carry`, output, 1: one-cycle pulse on wrap, in either direction.
- `scan_bcd`, output, 4: BCD value of the currently selected digit, to the decoder.
- `scan_sel`, output, DIGITS: one-hot active-low digit enable.

## Operation
- **Priority:** `clr` > `load` > `en`.
- **Clear:** `count` = 0; `carry` = 0.
- **Load:** each digit of `load_val` above 9 is replaced by 0; all other digits load unchanged; `carry` = 0.
- **Count up:**
  - Digit 0 increments.
  - A digit at 9 goes to 0 and carries into the next digit, rippling through the full width in one cycle.
  - All digits at 9 → all 0, with `carry` = 1.
- **Count down:**
  - A digit at 0 goes to 9 and borrows from the next digit.
  - All digits at 0 → all 9, with `carry` = 1.
- **Hold:** with `en` = 0, `count` holds and `carry` = 0.
- **Scan divider:**
  - Cycle counter `div` runs 0..SCAN_DIV-1 continuously and is independent of `en`, `clr` and `load`.
  - When `div` = SCAN_DIV-1, digit index `idx` advances; DIGITS-1 wraps to 0.
- **Scan outputs:**
  - `scan_sel` bit `idx` = 0; all other bits = 1.
  - `scan_bcd` = digit `idx` of `count`.
  - Both are registered together, so they always refer to the same digit; there is no glitch between them.
- **Scan state machine:** states DIG0..DIG(DIGITS-1), i.e. the value of `idx`. The only transition is DIGk → DIG((k+1) mod DIGITS) on divider terminal count.

## Timing
- **Reset values** (asynchronous, with `rst_n` low): `count` = 0, `carry` = 0, `div` = 0, `idx` = 0, `scan_sel` = all ones except bit 0 = 0, `scan_bcd` = 0.
- **Count latency:** `count` reflects an `en`/`clr`/`load` sampled at edge N immediately after edge N.
- **Carry:** `carry` is high for exactly the cycle after the wrapping edge.
- **Scan latency:**
  - `scan_bcd` and `scan_sel` are registered from the next-state `idx` and the next-state `count`.
  - A count change at edge N appears on `scan_bcd` at edge N if that digit is currently selected.
- **Dwell:** each digit is selected for exactly SCAN_DIV cycles. The first digit change after reset release occurs SCAN_DIV edges later.
- **Simultaneous events:**
  - `clr` together with `load`/`en`: clear wins; no carry.
  - A wrap coinciding with a scan advance: both take effect on the same edge.
- **Mid-operation reset:** asserting `rst_n` low at any time forces the reset values immediately and does not wait for a clock edge. Counting resumes on the first edge after release.

## Test plan
All scenarios use DIGITS = 4, SCAN_DIV = 4.
- **Reset:** drive `rst_n` low mid-count at `count` = 0x0123 → outputs go to reset values without a clock edge; `scan_sel` = 4'b1110.
- **Up wrap:** load 0x9998, then `en` = 1, `up_dn` = 1 for 2 cycles → `count` 0x9999, then 0x0000; `carry` high only in the cycle `count` reads 0x0000.
- **Down borrow:** load 0x1000, then one down step → 0x0999. Load 0x0000, then one down step → 0x9999 with `carry` pulse.
- **Invalid load and priority:** load 0xA5F3 → `count` = 0x0503. Assert `clr`, `load` and `en` in the same cycle → `count` = 0x0000.
- **Scan sequence:** with `count` = 0x4321 held, `scan_sel`/`scan_bcd` step through 1110/1, 1101/2, 1011/3, 0111/4, then back to 1110/1. Each pair lasts exactly 4 cycles, and both signals change on the same edge.
- **Count during scan:** with digit 0 selected, step `count` from 0x0008 to 0x0009 → `scan_bcd` shows 9 on the same edge that `count` changes.
